// File: rtl/peripheral_spram_arbiter_wb.sv
// peripheral_spram_arbiter_wb
//   Two-master Wishbone classic slave that shares one single-port RAM
//   (4 byte-lane write enables, registered read with one edge of latency).
//   Masters m0/m1 are arbitrated round-robin. Every granted transfer runs
//   IDLE -> ACCESS -> ACK: one RAM access, then ack (in range) or err
//   (word index >= DEPTH) to the owning master.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   wb_mX_adr_i          byte address; word index = adr[AW+1:2]
//   wb_mX_dat_i/sel_i    write data / byte selects
//   wb_mX_we_i           write strobe
//   wb_mX_cyc_i/stb_i    bus cycle / strobe (request = cyc & stb)
//   wb_mX_dat_o          read data (owner, ACK cycle only, else 0)
//   wb_mX_ack_o/err_o    acknowledge / error (owner, ACK cycle only)
//   ram_we               RAM byte write enables (nonzero only in ACCESS)
//   ram_din              RAM write data
//   ram_waddr/ram_raddr  RAM word address (identical values)
//   ram_dout             RAM read data, valid one edge after ram_raddr
module peripheral_spram_arbiter_wb #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic [AW+1:0] wb_m0_adr_i,
  input  logic [DW-1:0] wb_m0_dat_i,
  input  logic [3:0]    wb_m0_sel_i,
  input  logic          wb_m0_we_i,
  input  logic          wb_m0_cyc_i,
  input  logic          wb_m0_stb_i,
  output logic [DW-1:0] wb_m0_dat_o,
  output logic          wb_m0_ack_o,
  output logic          wb_m0_err_o,

  input  logic [AW+1:0] wb_m1_adr_i,
  input  logic [DW-1:0] wb_m1_dat_i,
  input  logic [3:0]    wb_m1_sel_i,
  input  logic          wb_m1_we_i,
  input  logic          wb_m1_cyc_i,
  input  logic          wb_m1_stb_i,
  output logic [DW-1:0] wb_m1_dat_o,
  output logic          wb_m1_ack_o,
  output logic          wb_m1_err_o,

  output logic [3:0]    ram_we,
  output logic [DW-1:0] ram_din,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  // One bit wider than the index so DEPTH == 2**AW is representable.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state;
  logic          owner;       // 0 = m0, 1 = m1
  logic          last_grant;
  logic          is_err;
  logic          is_wr;
  logic          abandoned;   // owner dropped its request during ACCESS
  logic [AW-1:0] ram_addr;

  logic          req0, req1;
  logic          grant;
  logic [AW-1:0] idx0, idx1, idx_s;
  logic [DW-1:0] dat_s;
  logic [3:0]    sel_s;
  logic          we_s;
  logic          in_range;
  logic          owner_req;
  logic          resp;

  // Byte offset bits carry no information for a word-wide RAM.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^{wb_m0_adr_i[1:0], wb_m1_adr_i[1:0]};

  assign req0 = wb_m0_cyc_i & wb_m0_stb_i;
  assign req1 = wb_m1_cyc_i & wb_m1_stb_i;
  assign idx0 = wb_m0_adr_i[AW+1:2];
  assign idx1 = wb_m1_adr_i[AW+1:2];

  // Round-robin: a lone requester wins; on a tie the master that did not
  // win last time gets the bus.
  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last_grant;
    end else begin
      grant = req1;
    end
  end

  always_comb begin
    idx_s = idx0;
    dat_s = wb_m0_dat_i;
    sel_s = wb_m0_sel_i;
    we_s  = wb_m0_we_i;
    if (grant) begin
      idx_s = idx1;
      dat_s = wb_m1_dat_i;
      sel_s = wb_m1_sel_i;
      we_s  = wb_m1_we_i;
    end
  end

  assign in_range = ({1'b0, idx_s} < DEPTH_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      is_err     <= 1'b0;
      is_wr      <= 1'b0;
      abandoned  <= 1'b0;
      ram_we     <= '0;
      ram_din    <= '0;
      ram_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner      <= grant;
            last_grant <= grant;
            ram_addr   <= idx_s;
            ram_din    <= dat_s;
            ram_we     <= (we_s && in_range) ? sel_s : 4'h0;
            is_err     <= ~in_range;
            is_wr      <= we_s;
            abandoned  <= 1'b0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          // The RAM commits the write / captures the read at this edge;
          // the access completes even if the owner has gone away.
          ram_we    <= '0;
          abandoned <= ~owner_req;
          state     <= ACK;
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          ram_we <= '0;
        end
      endcase
    end
  end

  assign ram_waddr = ram_addr;
  assign ram_raddr = ram_addr;

  // Response is qualified by the owner's live request so that a master that
  // drops cyc/stb in ACCESS or ACK never sees ack/err. Read data arrives
  // from the RAM only during ACK, so dat_o is steered combinationally.
  assign owner_req = owner ? req1 : req0;
  assign resp      = (state == ACK) & owner_req & ~abandoned;

  assign wb_m0_ack_o = resp & ~owner & ~is_err;
  assign wb_m0_err_o = resp & ~owner &  is_err;
  assign wb_m1_ack_o = resp &  owner & ~is_err;
  assign wb_m1_err_o = resp &  owner &  is_err;

  assign wb_m0_dat_o = (wb_m0_ack_o && !is_wr) ? ram_dout : '0;
  assign wb_m1_dat_o = (wb_m1_ack_o && !is_wr) ? ram_dout : '0;

endmodule

// File: tb/tb_peripheral_spram_arbiter_wb.sv
module tb_peripheral_spram_arbiter_wb;

  localparam int DEPTH = 200;
  localparam int AW    = $clog2(DEPTH);
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;

  logic [AW+1:0] m0_adr, m1_adr;
  logic [31:0]   m0_dat, m1_dat;
  logic [3:0]    m0_sel, m1_sel;
  logic          m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
  logic [31:0]   m0_dato, m1_dato;
  logic          m0_ack, m1_ack, m0_err, m1_err;

  logic [3:0]    ram_we;
  logic [31:0]   ram_din, ram_dout;
  logic [AW-1:0] ram_waddr, ram_raddr;

  always #5 clk = ~clk;

  peripheral_spram_arbiter_wb #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .wb_m0_adr_i(m0_adr), .wb_m0_dat_i(m0_dat), .wb_m0_sel_i(m0_sel),
    .wb_m0_we_i(m0_we), .wb_m0_cyc_i(m0_cyc), .wb_m0_stb_i(m0_stb),
    .wb_m0_dat_o(m0_dato), .wb_m0_ack_o(m0_ack), .wb_m0_err_o(m0_err),
    .wb_m1_adr_i(m1_adr), .wb_m1_dat_i(m1_dat), .wb_m1_sel_i(m1_sel),
    .wb_m1_we_i(m1_we), .wb_m1_cyc_i(m1_cyc), .wb_m1_stb_i(m1_stb),
    .wb_m1_dat_o(m1_dato), .wb_m1_ack_o(m1_ack), .wb_m1_err_o(m1_err),
    .ram_we(ram_we), .ram_din(ram_din), .ram_waddr(ram_waddr),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout)
  );

  // Generic single-port RAM with byte lanes and a registered read.
  logic [31:0] ram [0:(1<<AW)-1] = '{default: '0};
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) ram[ram_waddr][8*b +: 8] <= ram_din[8*b +: 8];
    ram_dout <= ram[ram_raddr];
  end

  // Reference model: word array, byte merge, round-robin last-grant bit.
  logic [31:0] mdl [0:255] = '{default: '0};
  bit lg = 1'b1;

  typedef struct {
    bit          we;
    int          idx;
    logic [31:0] dat;
    logic [3:0]  sel;
  } op_t;

  typedef struct {
    int          m;
    op_t         op;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  function automatic logic [AW+1:0] adr_of(input int idx);
    return (AW+2)'(idx * 4);
  endfunction

  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) return lg ? 0 : 1;
    return r1 ? 1 : 0;
  endfunction

  function automatic void model_op(input int m, input op_t o, output bit err, output logic [31:0] rd);
    err = (o.idx >= DEPTH);
    rd  = '0;
    if (!err) begin
      if (o.we) begin
        for (int b = 0; b < 4; b++)
          if (o.sel[b]) mdl[o.idx][8*b +: 8] = o.dat[8*b +: 8];
      end else begin
        rd = mdl[o.idx];
      end
    end
    lg = (m == 1);
  endfunction

  function automatic op_t mkop(input bit we, input int idx, input logic [31:0] dat, input logic [3:0] sel);
    op_t o;
    o.we = we; o.idx = idx; o.dat = dat; o.sel = sel;
    return o;
  endfunction

  function automatic vec_t mk(input int m, input bit we, input int idx, input logic [31:0] dat,
                              input logic [3:0] sel, input bit err, input logic [31:0] rd);
    vec_t v;
    v.m = m; v.op = mkop(we, idx, dat, sel); v.exp_err = err; v.exp_rd = rd;
    return v;
  endfunction

  task automatic drive(input int m, input bit req, input op_t o);
    if (m == 0) begin
      m0_cyc = req; m0_stb = req; m0_we = o.we; m0_adr = adr_of(o.idx);
      m0_dat = o.dat; m0_sel = o.sel;
    end else begin
      m1_cyc = req; m1_stb = req; m1_we = o.we; m1_adr = adr_of(o.idx);
      m1_dat = o.dat; m1_sel = o.sel;
    end
  endtask

  task automatic drop_all();
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
  endtask

  // One transfer: requests presented in an IDLE cycle, ACCESS and ACK
  // checked on the following falling edges, requests dropped in ACK.
  task automatic run(input string tag, input bit r0, input bit r1, input op_t o0, input op_t o1,
                     input bit use_exp, input bit exp_err, input logic [31:0] exp_rd);
    int          w;
    op_t         o;
    bit          merr;
    bit          e_err;
    logic [31:0] mrd, e_dat;
    logic [3:0]  e_we;
    w = pick(r0, r1);
    if (w == 1) o = o1; else o = o0;
    model_op(w, o, merr, mrd);
    e_err = use_exp ? exp_err : merr;
    e_dat = (o.we || e_err) ? 32'h0 : (use_exp ? exp_rd : mrd);
    e_we  = (o.we && !e_err) ? o.sel : 4'h0;

    @(negedge clk);
    drive(0, r0, o0);
    drive(1, r1, o1);
    @(negedge clk);
    chk({tag, ".we_access"}, 32'(ram_we), 32'(e_we));
    chk({tag, ".addr"}, 32'({ram_waddr, ram_raddr}), 32'({AW'(o.idx), AW'(o.idx)}));
    chk({tag, ".early_resp"}, 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'h0);
    @(negedge clk);
    if (w == 0) begin
      chk({tag, ".m0_ack"}, 32'(m0_ack), 32'(!e_err));
      chk({tag, ".m0_err"}, 32'(m0_err), 32'(e_err));
      chk({tag, ".m0_dat"}, m0_dato, e_dat);
      chk({tag, ".m1_quiet"}, 32'({m1_ack, m1_err}), 32'h0);
      chk({tag, ".m1_dat"}, m1_dato, 32'h0);
    end else begin
      chk({tag, ".m1_ack"}, 32'(m1_ack), 32'(!e_err));
      chk({tag, ".m1_err"}, 32'(m1_err), 32'(e_err));
      chk({tag, ".m1_dat"}, m1_dato, e_dat);
      chk({tag, ".m0_quiet"}, 32'({m0_ack, m0_err}), 32'h0);
      chk({tag, ".m0_dat"}, m0_dato, 32'h0);
    end
    chk({tag, ".we_ack"}, 32'(ram_we), 32'h0);
    drop_all();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ram_we"}, 32'(ram_we), 32'h0);
    chk({tag, ".ram_addr"}, 32'({ram_waddr, ram_raddr}), 32'h0);
    chk({tag, ".ram_din"}, ram_din, 32'h0);
    chk({tag, ".resp"}, 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'h0);
    chk({tag, ".m0_dat"}, m0_dato, 32'h0);
    chk({tag, ".m1_dat"}, m1_dato, 32'h0);
  endtask

  vec_t vecs [13];
  op_t  nop;

  initial begin
    vecs[0]  = mk(0, 1, 4,   32'hDEADBEEF, 4'hF, 0, 32'h0);
    vecs[1]  = mk(0, 0, 4,   32'h0,        4'hF, 0, 32'hDEADBEEF);
    vecs[2]  = mk(0, 1, 4,   32'h11223344, 4'hF, 0, 32'h0);
    vecs[3]  = mk(1, 1, 4,   32'hAABBCCDD, 4'h5, 0, 32'h0);
    vecs[4]  = mk(1, 0, 4,   32'h0,        4'hF, 0, 32'h11BB33DD);
    vecs[5]  = mk(0, 1, 200, 32'h55555555, 4'hF, 1, 32'h0);
    vecs[6]  = mk(0, 0, 200, 32'h0,        4'hF, 1, 32'h0);
    vecs[7]  = mk(1, 1, 199, 32'hCAFEBABE, 4'hF, 0, 32'h0);
    vecs[8]  = mk(0, 0, 199, 32'h0,        4'hF, 0, 32'hCAFEBABE);
    vecs[9]  = mk(1, 1, 5,   32'h12345678, 4'h0, 0, 32'h0);
    vecs[10] = mk(1, 0, 5,   32'h0,        4'hF, 0, 32'h0);
    vecs[11] = mk(0, 1, 199, 32'hFFFFFFFF, 4'h8, 0, 32'h0);
    vecs[12] = mk(1, 0, 199, 32'h0,        4'hF, 0, 32'hFFFEBABE);
    nop = mkop(0, 0, 32'h0, 4'h0);

    rst = 1'b1;
    drive(0, 0, nop);
    drive(1, 0, nop);
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 13; i++)
      run($sformatf("vec%0d", i), vecs[i].m == 0, vecs[i].m == 1,
          vecs[i].op, vecs[i].op, 1'b1, vecs[i].exp_err, vecs[i].exp_rd);

    // Round-robin: both masters hold read requests for four transfers.
    begin
      op_t r0op, r1op;
      int  w;
      bit  e;
      logic [31:0] rd;
      r0op = mkop(0, 4, 32'h0, 4'hF);
      r1op = mkop(0, 199, 32'h0, 4'hF);
      @(negedge clk);
      drive(0, 1, r0op);
      drive(1, 1, r1op);
      for (int j = 1; j <= 11; j++) begin
        @(negedge clk);
        if (j % 3 == 2) begin
          w = pick(1, 1);
          if (w == 0) model_op(0, r0op, e, rd); else model_op(1, r1op, e, rd);
          chk($sformatf("rr%0d.m0_ack", j), 32'(m0_ack), 32'(w == 0));
          chk($sformatf("rr%0d.m1_ack", j), 32'(m1_ack), 32'(w == 1));
          chk($sformatf("rr%0d.dat", j), (w == 0) ? m0_dato : m1_dato, rd);
          chk($sformatf("rr%0d.other_dat", j), (w == 0) ? m1_dato : m0_dato, 32'h0);
        end else begin
          chk($sformatf("rr%0d.idle_ack", j), 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
        end
      end
      drop_all();
    end

    // Abandon: m1 drops cyc during ACCESS of a write; write still lands.
    begin
      op_t o;
      bit  e;
      logic [31:0] rd;
      o = mkop(1, 7, 32'h12345678, 4'hF);
      @(negedge clk);
      drive(1, 1, o);
      @(negedge clk);
      chk("abandon.we_access", 32'(ram_we), 32'hF);
      m1_cyc = 1'b0;
      @(negedge clk);
      chk("abandon.m1_resp", 32'({m1_ack, m1_err}), 32'h0);
      chk("abandon.m0_resp", 32'({m0_ack, m0_err}), 32'h0);
      drop_all();
      model_op(1, o, e, rd);
      run("abandon.readback", 1, 0, mkop(0, 7, 32'h0, 4'hF), nop, 1'b1, 1'b0, 32'h12345678);
    end

    // Reset during ACCESS of a write to word 3 (still 0).
    begin
      op_t o;
      o = mkop(1, 3, 32'hCAFEF00D, 4'hF);
      @(negedge clk);
      drive(0, 1, o);
      @(negedge clk);
      chk("rstmid.we_access", 32'(ram_we), 32'hF);
      #1 rst = 1'b1;
      #1 chk_reset_outputs("rstmid");
      drop_all();
      @(negedge clk);
      chk_reset_outputs("rstmid.held");
      @(negedge clk);
      rst = 1'b0;
      lg = 1'b1;
      run("rstmid.readback", 1, 0, mkop(0, 3, 32'h0, 4'hF), nop, 1'b1, 1'b0, 32'h0);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 200; k++) begin
      int  mask;
      op_t a, b;
      mask = $urandom_range(1, 3);
      a = mkop(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom, 4'($urandom_range(0, 15)));
      b = mkop(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom, 4'($urandom_range(0, 15)));
      run($sformatf("rnd%0d", k), mask[0], mask[1], a, b, 1'b0, 1'b0, 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/peripheral_spram_arbiter_wb.md
Name: peripheral_spram_arbiter_wb

Overview:
- Two-master Wishbone classic slave controller that sequences and shares one generic single-port RAM: 4 byte-lane write enables, separate write/read address, 1-cycle registered read.
- Round-robin arbitration between master ports m0 and m1.
- Issues one RAM access per granted transfer and returns ack, or err for out-of-range addresses.
- Sits between the interconnect and the RAM instance in the SPRAM peripheral.

Parameters:
- DEPTH, 256, RAM depth in 32-bit words; need not be a power of two.
- AW, $clog2(DEPTH), RAM word-address width.
- DW, 32, data width; fixed at 32, four byte lanes.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- wb_m0_adr_i  in  AW+2  m0 byte address; word index = adr[AW+1:2].
- wb_m0_dat_i  in  DW  m0 write data.
- wb_m0_sel_i  in  4  m0 byte selects.
- wb_m0_we_i  in  1  m0 write strobe.
- wb_m0_cyc_i  in  1  m0 bus cycle.
- wb_m0_stb_i  in  1  m0 strobe.
- wb_m0_dat_o  out  DW  m0 read data.
- wb_m0_ack_o  out  1  m0 acknowledge.
- wb_m0_err_o  out  1  m0 error.
- wb_m1_*: same set as m0, for master 1.
- ram_we  out  4  RAM byte write enables.
- ram_din  out  DW  RAM write data.
- ram_waddr  out  AW  RAM write address.
- ram_raddr  out  AW  RAM read address; same value as ram_waddr.
- ram_dout  in  DW  RAM read data; valid one edge after ram_raddr is presented.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Request: req_m = cyc & stb.
- States: IDLE, ACCESS, ACK.
- IDLE:
  - If any req, grant a master, latch owner, and register ram_waddr/ram_raddr = word index and ram_din = dat_i.
  - ram_we = sel if we & in-range, else 0.
  - Latch flags is_err (index >= DEPTH) and is_wr.
  - Go to ACCESS.
- ACCESS (exactly 1 cycle):
  - RAM performs the write / captures the read at the closing edge.
  - ram_we returns to 0 at that edge.
  - Go to ACK.
- ACK (exactly 1 cycle):
  - Owner gets ack_o = ~is_err & cyc & stb, or err_o = is_err & cyc & stb.
  - Owner dat_o = ram_dout for reads; 0 for writes, err, and the non-owner.
  - Go to IDLE unconditionally.
- Latency: request sampled in IDLE at cycle N; ack/err high during cycle N+2. Throughput is one transfer per 3 cycles.
- ram_we is nonzero only during ACCESS; never nonzero for an erroring or read transfer.
- Arbitration:
  - Round-robin via last_grant register.
  - Single requester wins.
  - Both requesting: grant ~last_grant.
  - last_grant updates on every grant.
  - Grant is evaluated only in IDLE, so no preemption.
- Abandonment: if the owner drops cyc/stb during ACCESS or ACK, the access still completes (a write is committed) and ack/err is suppressed. FSM still returns to IDLE.
- sel = 0 write: transfer is acked, memory unchanged.
- Non-owner ack/err/dat_o are always 0.
- Reset values: state IDLE; last_grant = 1 (m0 wins first tie); ram_we 0; ram_waddr/ram_raddr/ram_din 0; all ack_o/err_o 0; all dat_o 0.
- Reset mid-operation: asserting rst in ACCESS clears ram_we asynchronously, so the in-flight write does not occur. No ack is produced. After release, a still-asserted request is re-arbitrated from IDLE.
- A request held after ACK is treated as a new transfer (classic, no bursts; cti/bte not supported).

Test Plan:
- Single write then read: m0 writes adr 0x010, dat 0xDEADBEEF, sel 0xF; ack in cycle N+2, ram_we = 0xF during ACCESS only. m0 then reads 0x010 and gets dat_o = 0xDEADBEEF with ack 2 cycles after the request.
- Byte lanes: preload word 4 = 0x11223344; m1 writes 0xAABBCCDD with sel 0x5 -> readback 0x11BB33DD.
- Round-robin: m0 and m1 both request continuously with reads -> grants m0, m1, m0, m1. Each ack arrives on its owner only, every 3 cycles; the non-owner's ack stays 0.
- Out of range (DEPTH = 200): m0 writes word index 200 (adr 0x320) -> err_o high at N+2, ack_o 0, ram_we stays 0. Reading index 199 still works.
- Abandon: m1 drops cyc in ACCESS of a write to word 7 = 0x12345678 -> no ack to m1, and a later read of word 7 returns 0x12345678.
- Reset mid-write: rst asserted during ACCESS of a write 0xCAFEF00D to word 3 (old 0) -> ram_we 0 immediately, all outputs at reset values, and word 3 reads back 0 after release.
